occ_fetch: RTL
==============

# occ_fetch

Parametrised Occ-table fetch stage for the backtracking search pipeline. It sits between the parameter stage and the interval-update stage. It accepts one search tuple (i, z, k, l, addr, position) per transaction, and for symbol-bearing positions it reads the Occ ROM at k-1 and at l. It slices out the per-symbol count for the symbol named by position and hands the tuple plus both counts downstream over valid/ready.

## Interface
- PW, 8: width of i, z, k, l.
- AW, 12: width of the parameter address.
- POSW, 5: width of the position code.
- NSYM, 4: symbols per Occ ROM word (A, C, G, T).
- OCCW, 8: width of one Occ count; ROM word is NSYM*OCCW.
- ROMAW, 8: Occ ROM address width; k-1 and l are truncated to ROMAW LSBs.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input tuple valid.
- in_ready  out  1  block can accept a tuple.
- i_in, z_in, k_in, l_in  in  PW each  search parameters.
- addr_in  in  AW  parameter address.
- position_in  in  POSW  position code.
- rom_ce  out  1  Occ ROM read request.
- rom_addr  out  ROMAW  Occ ROM address.
- rom_data  in  NSYM*OCCW  Occ ROM word.
- rom_valid  in  1  rom_data valid; sampled only while rom_ce=1.
- out_valid  out  1  output tuple valid.
- out_ready  in  1  downstream accepts.
- i_out, z_out, k_out, l_out  out  PW each  registered copies of the inputs.
- addr_out  out  AW  registered copy of addr_in.
- position_out  out  POSW  registered copy of position_in.
- occ_k_out  out  OCCW  Occ(sym, k-1); 0 if k=0 or bypass.
- occ_l_out  out  OCCW  Occ(sym, l); 0 on bypass.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, register all fields and decode sym from position (see below).
    - Bypass (NONE, STOP_1, STOP_2, or an unknown code): clear both counts, go to OUT.
    - Else if k_in=0: occ_k=0, go to RD_L.
    - Else go to RD_K.
  - RD_K: rom_ce=1, rom_addr=k-1. On rom_valid, capture occ_k = rom_data[sym*OCCW +: OCCW] and go to RD_L.
  - RD_L: rom_ce=1, rom_addr=l. On rom_valid, capture occ_l from the same slice and go to OUT.
  - OUT: out_valid=1; all outputs held stable. On out_ready go to IDLE.
- Symbol decode:
  - *_MATCH, *_SNP, *_INSERTION, *_DELETION map to sym A=0, C=1, G=2, T=3.
- Input hold: in_ready is 0 outside IDLE, so no new tuple is taken while busy and there is no skid buffer.
- ROM protocol:
  - At most one outstanding ROM request.
  - rom_ce and rom_addr stay constant until rom_valid.
  - rom_valid may arrive in the same cycle as rom_ce (combinational ROM) or any later cycle; there is no timeout.
- Arithmetic: k-1 is computed in PW bits and then truncated to ROMAW; underflow is impossible because k=0 skips RD_K.

## Timing
- Reset values:
  - State IDLE; in_ready=1.
  - rom_ce=0, rom_addr=0, out_valid=0.
  - All data outputs 0.
- Reset mid-operation (any state): return to IDLE next edge, in-flight tuple discarded, rom_ce drops. A late rom_valid is ignored because rom_ce=0.
- Latency, tuple accepted at edge T, zero-wait ROM:
  - Bypass: out_valid at T+1.
  - k=0: out_valid at T+2.
  - Full fetch: out_valid at T+3.
  - Each ROM wait cycle adds one cycle.
- Throughput: one tuple per (latency + 1) cycles, because IDLE must be re-entered before the next tuple.
- Back-pressure: out_valid stays high with stable data until out_ready. Output accepted at edge E gives in_ready=1 at E+1.

## Structure
- Shared package (shared with the parameter and update stages):
  - Position codes: NONE, STOP_1, STOP_2, {A,C,G,T}_{MATCH,SNP,INSERTION,DELETION}.
  - Symbol index constants SYM_A..SYM_T.
  - FSM state enum.
- Sub-module: occ_slice, a combinational selector giving position → sym, a bypass flag, and the OCCW slice of the ROM word. It is reused by the update stage.

## Test plan
- Reset: assert rst during RD_K with rom_ce=1 → next cycle rom_ce=0, in_ready=1, out_valid=0, all outputs 0.
- Full fetch: C_INSERTION, k=5, l=9, ROM returns word 0x44332211 at addr 4 and 0x88776655 at addr 9 → rom_addr sequence 4 then 9; occ_k_out=0x22, occ_l_out=0x66; out_valid at T+3.
- k=0 with T_MATCH, l=7, word 0xAA000000 at addr 7 → single ROM read; occ_k_out=0, occ_l_out=0xAA; out_valid at T+2.
- Bypass: STOP_1, k=3 → rom_ce never asserted; out_valid at T+1 with both counts 0 and all fields passed through.
- Stalls: rom_valid delayed 3 cycles on each read and out_ready held low 4 cycles → rom_addr held stable throughout, outputs stable while out_valid, in_ready=0 until the accept edge +1.
- Back-to-back: two tuples presented continuously → the second is accepted only after the first completes; no field mixing between tuples.

Source files
------------

// File: rtl/occ_fetch_pkg.sv
// Shared definitions for the backtracking search pipeline: position codes,
// symbol indices and the fetch-stage FSM encoding.
package occ_fetch_pkg;

  localparam int unsigned SYMW = 2;

  localparam logic [SYMW-1:0] SYM_A = 2'd0;
  localparam logic [SYMW-1:0] SYM_C = 2'd1;
  localparam logic [SYMW-1:0] SYM_G = 2'd2;
  localparam logic [SYMW-1:0] SYM_T = 2'd3;

  // Symbol-bearing codes are packed as 4 + 4*sym + kind, kind = MATCH/SNP/INSERTION/DELETION.
  typedef enum logic [4:0] {
    POS_NONE        = 5'd0,
    POS_STOP_1      = 5'd1,
    POS_STOP_2      = 5'd2,
    POS_A_MATCH     = 5'd4,
    POS_A_SNP       = 5'd5,
    POS_A_INSERTION = 5'd6,
    POS_A_DELETION  = 5'd7,
    POS_C_MATCH     = 5'd8,
    POS_C_SNP       = 5'd9,
    POS_C_INSERTION = 5'd10,
    POS_C_DELETION  = 5'd11,
    POS_G_MATCH     = 5'd12,
    POS_G_SNP       = 5'd13,
    POS_G_INSERTION = 5'd14,
    POS_G_DELETION  = 5'd15,
    POS_T_MATCH     = 5'd16,
    POS_T_SNP       = 5'd17,
    POS_T_INSERTION = 5'd18,
    POS_T_DELETION  = 5'd19
  } pos_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_K = 2'd1,
    ST_RD_L = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/occ_slice.sv
// Combinational position decode and per-symbol count selection from one Occ ROM word.
module occ_slice
  import occ_fetch_pkg::*;
#(
  parameter int unsigned POSW = 5,
  parameter int unsigned NSYM = 4,
  parameter int unsigned OCCW = 8
) (
  input  logic [POSW-1:0]      position_i,
  input  logic [NSYM*OCCW-1:0] rom_word_i,
  output logic [SYMW-1:0]      sym_o,
  output logic                 bypass_o,
  output logic [OCCW-1:0]      occ_o
);

  logic [POSW-1:0] rel;

  always_comb begin
    rel      = position_i - POSW'(POS_A_MATCH);
    bypass_o = (position_i < POSW'(POS_A_MATCH)) || (position_i > POSW'(POS_T_DELETION));
    sym_o    = rel[3:2];
    occ_o    = rom_word_i[sym_o*OCCW +: OCCW];
  end

endmodule

// File: rtl/occ_fetch.sv
// Occ-table fetch stage: reads Occ(sym, k-1) and Occ(sym, l) for one search tuple
// and presents the tuple plus both counts downstream over valid/ready.
module occ_fetch
  import occ_fetch_pkg::*;
#(
  parameter int unsigned PW    = 8,
  parameter int unsigned AW    = 12,
  parameter int unsigned POSW  = 5,
  parameter int unsigned NSYM  = 4,
  parameter int unsigned OCCW  = 8,
  parameter int unsigned ROMAW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PW-1:0]        i_in,
  input  logic [PW-1:0]        z_in,
  input  logic [PW-1:0]        k_in,
  input  logic [PW-1:0]        l_in,
  input  logic [AW-1:0]        addr_in,
  input  logic [POSW-1:0]      position_in,
  output logic                 rom_ce,
  output logic [ROMAW-1:0]     rom_addr,
  input  logic [NSYM*OCCW-1:0] rom_data,
  input  logic                 rom_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        i_out,
  output logic [PW-1:0]        z_out,
  output logic [PW-1:0]        k_out,
  output logic [PW-1:0]        l_out,
  output logic [AW-1:0]        addr_out,
  output logic [POSW-1:0]      position_out,
  output logic [OCCW-1:0]      occ_k_out,
  output logic [OCCW-1:0]      occ_l_out
);

  state_e          state_q, state_d;
  logic [PW-1:0]   i_q, i_d, z_q, z_d, k_q, k_d, l_q, l_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [POSW-1:0] pos_q, pos_d;
  logic [OCCW-1:0] occ_k_q, occ_k_d, occ_l_q, occ_l_d;

  logic [POSW-1:0] pos_sel;
  logic [SYMW-1:0] sym;
  logic            bypass;
  logic [OCCW-1:0] occ_sel;
  logic [PW-1:0]   k_m1;

  // One selector serves both the accept-time decode and the ROM slice in the read states.
  assign pos_sel = (state_q == ST_IDLE) ? position_in : pos_q;

  occ_slice #(
    .POSW (POSW),
    .NSYM (NSYM),
    .OCCW (OCCW)
  ) u_slice (
    .position_i (pos_sel),
    .rom_word_i (rom_data),
    .sym_o      (sym),
    .bypass_o   (bypass),
    .occ_o      (occ_sel)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    z_d     = z_q;
    k_d     = k_q;
    l_d     = l_q;
    addr_d  = addr_q;
    pos_d   = pos_q;
    occ_k_d = occ_k_q;
    occ_l_d = occ_l_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          i_d    = i_in;
          z_d    = z_in;
          k_d    = k_in;
          l_d    = l_in;
          addr_d = addr_in;
          pos_d  = position_in;
          if (bypass) begin
            occ_k_d = '0;
            occ_l_d = '0;
            state_d = ST_OUT;
          end else if (k_in == '0) begin
            occ_k_d = '0;
            state_d = ST_RD_L;
          end else begin
            state_d = ST_RD_K;
          end
        end
      end
      ST_RD_K: begin
        if (rom_valid) begin
          occ_k_d = occ_sel;
          state_d = ST_RD_L;
        end
      end
      ST_RD_L: begin
        if (rom_valid) begin
          occ_l_d = occ_sel;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      z_q     <= '0;
      k_q     <= '0;
      l_q     <= '0;
      addr_q  <= '0;
      pos_q   <= '0;
      occ_k_q <= '0;
      occ_l_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      z_q     <= z_d;
      k_q     <= k_d;
      l_q     <= l_d;
      addr_q  <= addr_d;
      pos_q   <= pos_d;
      occ_k_q <= occ_k_d;
      occ_l_q <= occ_l_d;
    end
  end

  always_comb begin
    k_m1     = k_q - PW'(1);
    rom_addr = '0;
    if (state_q == ST_RD_K)      rom_addr = ROMAW'(k_m1);
    else if (state_q == ST_RD_L) rom_addr = ROMAW'(l_q);
  end

  assign rom_ce       = (state_q == ST_RD_K) || (state_q == ST_RD_L);
  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_OUT);
  assign i_out        = i_q;
  assign z_out        = z_q;
  assign k_out        = k_q;
  assign l_out        = l_q;
  assign addr_out     = addr_q;
  assign position_out = pos_q;
  assign occ_k_out    = occ_k_q;
  assign occ_l_out    = occ_l_q;

endmodule
